// File: rtl/rv_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_enc_pkg: kind encodings, opcodes, funct3 and ext-type codes       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv_enc_pkg;

  typedef enum logic [2:0] {
    KIND_ADDI  = 3'd0,
    KIND_SLTI  = 3'd1,
    KIND_SLTIU = 3'd2,
    KIND_XORI  = 3'd3,
    KIND_LUI   = 3'd4,
    KIND_AUIPC = 3'd5,
    KIND_JAL   = 3'd6,
    KIND_JALR  = 3'd7
  } kind_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_JALR  = 3'b000;

  // Shared with the decoder-side immediate selector.
  localparam logic [1:0] IMM_I   = 2'b11;
  localparam logic [1:0] IMM_U   = 2'b01;
  localparam logic [1:0] IMM_JAL = 2'b10;

  function automatic logic [2:0] kind_f3(input logic [2:0] kind);
    case (kind)
      KIND_SLTI:  return F3_SLTI;
      KIND_SLTIU: return F3_SLTIU;
      KIND_XORI:  return F3_XORI;
      KIND_JALR:  return F3_JALR;
      default:    return F3_ADDI;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_enc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_enc_fifo: DEPTH x WIDTH synchronous FIFO with occupancy output    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == LVL_W'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = r_mem[r_rd_ptr];
  assign level  = r_level;

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_inst_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_inst_encoder: packs abstract requests into RV32I words + FIFO     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_kind,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs1,
  input  logic [31:0]            req_imm,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst,
  output logic [1:0]             inst_ext_type,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       err_cnt
  ,
  output logic [$clog2(DEPTH):0] level
);

  logic [31:0]      w_word;
  logic [1:0]       w_ext;
  logic             w_legal;
  logic             w_i_ok;
  logic             w_u_ok;
  logic             w_j_ok;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [33:0]      w_head;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_i_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign w_u_ok = ~(|req_imm[11:0]);
  assign w_j_ok = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];

  always_comb begin
    w_word  = '0;
    w_ext   = IMM_I;
    w_legal = 1'b0;
    case (req_kind)
      KIND_LUI, KIND_AUIPC: begin
        w_word  = {req_imm[31:12], req_rd, (req_kind == KIND_LUI) ? OP_LUI : OP_AUIPC};
        w_ext   = IMM_U;
        w_legal = w_u_ok;
      end
      KIND_JAL: begin
        w_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
        w_ext   = IMM_JAL;
        w_legal = w_j_ok;
      end
      default: begin
        w_word  = {req_imm[11:0], req_rs1, kind_f3(req_kind), req_rd,
                   (req_kind == KIND_JALR) ? OP_JALR : OP_IMM};
        w_ext   = IMM_I;
        w_legal = w_i_ok;
      end
    endcase
  end

  // Ready depends only on registered occupancy, never on inst_ready.
  assign req_ready = ~w_full;
  assign w_accept  = req_valid & req_ready;

  rv_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (34)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_accept & w_legal),
    .wdata ({w_ext, w_word}),
    .pop   (inst_valid & inst_ready),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign inst_valid    = ~w_empty;
  assign inst          = w_head[31:0];
  assign inst_ext_type = w_head[33:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept & ~w_legal;
      if (w_accept && !w_legal && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_inst_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_inst_encoder: directed + random bench with reference model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_inst_encoder;

  localparam int c_depth = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [31:0] req_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [1:0]  inst_ext_type;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [1:0]  level;

  int          checks = 0;
  int          failures = 0;
  logic [33:0] exp_q[$];
  bit          m_err_pulse = 0;
  int          m_err_cnt = 0;

  always #5 clk = ~clk;

  rv_inst_encoder #(.DEPTH(c_depth), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_rd        (req_rd),
    .req_rs1       (req_rs1),
    .req_imm       (req_imm),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_ext_type (inst_ext_type),
    .err_pulse     (err_pulse),
    .err_cnt       (err_cnt),
    .level         (level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: instruction fields assembled with shifts/masks from value ranges.
  function automatic void model_encode(input logic [2:0] k, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [31:0] imm,
                                       output logic [33:0] w, output bit legal);
    int          s;
    logic [31:0] word;
    logic [31:0] ops [8];
    logic [31:0] f3s [8];
    ops = '{32'h13, 32'h13, 32'h13, 32'h13, 32'h37, 32'h17, 32'h6F, 32'h67};
    f3s = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
    s = $signed(imm);
    if (k == 3'd4 || k == 3'd5) begin
      legal = (imm % 32'd4096) == 0;
      word  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | ops[k];
      w     = {2'b01, word};
    end else if (k == 3'd6) begin
      legal = (s >= -1048576) && (s <= 1048574) && ((imm & 32'd1) == 0);
      word  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
              (32'(rd) << 7) | ops[k];
      w     = {2'b10, word};
    end else begin
      legal = (s >= -2048) && (s <= 2047);
      word  = (imm << 20) | (32'(rs1) << 15) | (f3s[k] << 12) | (32'(rd) << 7) | ops[k];
      w     = {2'b11, word};
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ":req_ready"}, req_ready, exp_q.size() != c_depth);
    chk({ph, ":inst_valid"}, inst_valid, exp_q.size() != 0);
    chk({ph, ":level"}, level, exp_q.size());
    chk({ph, ":err_pulse"}, err_pulse, m_err_pulse);
    chk({ph, ":err_cnt"}, err_cnt, m_err_cnt);
    if (exp_q.size() != 0) begin
      chk({ph, ":inst"}, inst, exp_q[0][31:0]);
      chk({ph, ":ext"}, inst_ext_type, exp_q[0][33:32]);
    end
  endtask

  task automatic step(input string ph, input bit v, input logic [2:0] k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [31:0] imm, input bit rdy);
    logic [33:0] w;
    bit          legal, acc, pop;
    req_valid = v; req_kind = k; req_rd = rd; req_rs1 = rs1; req_imm = imm; inst_ready = rdy;
    model_encode(k, rd, rs1, imm, w, legal);
    acc = v && (exp_q.size() != c_depth);
    pop = rdy && (exp_q.size() != 0);
    @(posedge clk); #1;
    if (pop) void'(exp_q.pop_front());
    if (acc && legal) exp_q.push_back(w);
    m_err_pulse = acc && !legal;
    if (acc && !legal && m_err_cnt != 255) m_err_cnt++;
    check_all(ph);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] b [7];
    logic [31:0] r;
    b = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd1048574, -32'sd1048576, 32'd1048576};
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r;
      1:       return {{21{r[11]}}, r[10:0]};
      2:       return {r[31:12], 12'h000};
      3:       return {{12{r[20]}}, r[19:1], 1'b0};
      default: return b[$urandom_range(0, 6)];
    endcase
  endfunction

  initial begin
    #2;
    chk("rst:inst_valid", inst_valid, 1'b0);
    chk("rst:level", level, 2'd0);
    chk("rst:inst", inst, 32'h0);
    chk("rst:ext", inst_ext_type, 2'b00);
    chk("rst:err_pulse", err_pulse, 1'b0);
    chk("rst:err_cnt", err_cnt, 8'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst:req_ready", req_ready, 1'b1);

    step("addi", 1, 3'd0, 5'd1, 5'd0, 32'd5, 1);
    chk("addi_word", inst, 32'h00500093);
    chk("addi_ext", inst_ext_type, 2'b11);
    step("addi_drain", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);
    chk("addi_level0", level, 2'd0);

    step("lui", 1, 3'd4, 5'd5, 5'd0, 32'h12345000, 0);
    chk("lui_word", inst, 32'h123452B7);
    chk("lui_ext", inst_ext_type, 2'b01);
    step("lui_drain", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);
    step("jal", 1, 3'd6, 5'd1, 5'd0, -32'sd4, 0);
    chk("jal_word", inst, 32'hFFDFF0EF);
    chk("jal_ext", inst_ext_type, 2'b10);
    step("jal_drain", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);

    step("xori_bad", 1, 3'd3, 5'd2, 5'd3, 32'd2048, 1);
    chk("xori_pulse", err_pulse, 1'b1);
    chk("xori_cnt", err_cnt, 8'd1);
    step("idle", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);
    chk("pulse_clear", err_pulse, 1'b0);
    step("jal_odd", 1, 3'd6, 5'd1, 5'd0, 32'd3, 1);
    step("lui_bad", 1, 3'd4, 5'd1, 5'd0, 32'd1, 1);
    chk("err_cnt3", err_cnt, 8'd3);

    step("bp1", 1, 3'd0, 5'd1, 5'd1, 32'd11, 0);
    step("bp2", 1, 3'd1, 5'd2, 5'd2, 32'd22, 0);
    step("bp3_full", 1, 3'd2, 5'd3, 5'd3, 32'd33, 0);
    chk("bp_level2", level, 2'd2);
    chk("bp_ready0", req_ready, 1'b0);
    step("bp3_pop", 1, 3'd2, 5'd3, 5'd3, 32'd33, 1);
    step("bp3_acc", 1, 3'd2, 5'd3, 5'd3, 32'd33, 0);
    for (int i = 0; i < 3; i++) step("bp_drain", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);

    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        step("stream_jalr", 1, 3'd7, 5'd0, 5'd2, -32'sd2048, 1);
        chk("jalr_word", inst, 32'h80010067);
      end else begin
        step("stream", 1, 3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
             {{21{1'b0}}, 11'($urandom)}, 1);
      end
    end
    step("stream_drain", 0, 3'd0, 5'd0, 5'd0, 32'd0, 1);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), 3'($urandom), 5'($urandom), 5'($urandom),
           rand_imm(), ($urandom_range(0, 2) != 0));

    step("fill1", 1, 3'd0, 5'd7, 5'd1, 32'd1, 0);
    step("fill2", 1, 3'd0, 5'd8, 5'd1, 32'd2, 0);
    chk("pre_rst_level", level, 2'd2);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst:inst_valid", inst_valid, 1'b0);
    chk("arst:level", level, 2'd0);
    chk("arst:err_cnt", err_cnt, 8'd0);
    chk("arst:inst", inst, 32'h0);
    exp_q.delete();
    m_err_cnt = 0;
    m_err_pulse = 0;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step("sat", 1, 3'd0, 5'd1, 5'd1, 32'd4096, 1);
    chk("sat_255", err_cnt, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Encoder counterpart to the NPC decode-side immediate-class selector. It accepts abstract instruction requests (kind, rd, rs1, 32-bit immediate) over a valid/ready handshake.
- It packs each request into a 32-bit RV32I instruction word, checks the immediate's range, and buffers the result in a small FIFO for a valid/ready consumer.
- Used by the self-test instruction generator feeding the IFU test path. Also emits the 2-bit immediate-class code the decoder must recover, so the stream is self-checking.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_kind  in  3  0 ADDI, 1 SLTI, 2 SLTIU, 3 XORI, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register; ignored for LUI/AUIPC/JAL.
- req_imm  in  32  signed byte-offset/immediate value (U kinds: full 32-bit value).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  consumer takes the head.
- inst  out  32  encoded instruction at the FIFO head.
- inst_ext_type  out  2  class of the head: 2'b11 I (incl. JALR), 2'b01 U, 2'b10 J, 2'b00 never produced.
- err_pulse  out  1  one-cycle pulse: last accepted request was rejected.
- err_cnt  out  CNT_W  saturating count of rejected requests.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low): FIFO empty, level=0, inst_valid=0, inst=0, inst_ext_type=0, err_pulse=0, err_cnt=0. req_ready=1 once rst_n is released.
  - Reset mid-transfer discards all buffered entries; no partial state survives.
- req_ready = (level != DEPTH). Registered-only decision: no combinational path from inst_ready.
  - When full, a simultaneous pop does not enable a push that cycle.
- Accept = req_valid & req_ready. The encode and legality check are combinational on the request; the result is pushed at the accepting edge.
  - Latency: accept at edge N -> inst_valid=1 after edge N (visible cycle N+1) if the FIFO was empty.
- Legality; an illegal request is accepted but not pushed. At the same edge err_pulse<=1 (1 cycle) and err_cnt increments, saturating at all-ones. Rules:
  - I kinds (0-3, 7): req_imm[31:11] all equal (range -2048..2047).
  - U kinds (4, 5): req_imm[11:0]==0.
  - JAL (6): req_imm[31:20] all equal and req_imm[0]==0 (range -1048576..1048574, even).
- Encoding:
  - I: {imm[11:0], rs1, f3, rd, op}.
    - op 0010011 for kinds 0-3, with f3 = 000/010/011/100.
    - JALR: op 1100111, f3 000.
  - U: {imm[31:12], rd, op}; LUI op 0110111, AUIPC op 0010111.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
- FIFO:
  - inst/inst_ext_type always show the head entry. Pop = inst_valid & inst_ready.
  - Push and pop in the same cycle leave level unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Pop when empty is ignored.
- inst and inst_ext_type must hold stable while inst_valid=1 and inst_ready=0.

Decomposition:
- Package rv_enc_pkg holds:
  - the kind encodings;
  - opcode constants OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR;
  - funct3 constants;
  - ext-type codes IMM_I=2'b11, IMM_U=2'b01, IMM_JAL=2'b10, shared with the decoder-side selector.
- One sub-module, rv_enc_fifo: a parameterised DEPTH x 34-bit synchronous FIFO with level output and async active-low reset.
- Encode and legality logic stay in the top module.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5, inst_ready=1 -> next cycle inst=32'h00500093, ext=11; level returns to 0 one cycle later.
- LUI rd=5 imm=32'h12345000 -> inst=32'h123452B7, ext=01. Then JAL rd=1 imm=-4 -> inst=32'hFFDFF0EF, ext=10.
- XORI imm=2048 (illegal) -> accepted, no push, err_pulse high 1 cycle, err_cnt=1. JAL imm=3 -> err_cnt=2. LUI imm=32'h00000001 -> err_cnt=3.
- inst_ready=0; push 3 legal requests with DEPTH=2 -> req_ready drops after 2, level=2, head stable. Raise inst_ready for one cycle -> pop one; the third request is accepted the following cycle; order preserved.
- Continuous push/pop with req_valid=inst_ready=1 for 10 requests (JALR imm=-2048 rs1=2 -> 32'h80010067 among them) -> level steady, all words in order, pointers wrap.
- Assert rst_n low while level=2 -> inst_valid, level, err_cnt=0 immediately, without waiting for a clock edge. 300 illegal requests -> err_cnt saturates at 255.
